log_scale_mul_sched: RTL and testbench
======================================

// Module: log_scale_mul_sched
// PURPOSE
// - Controller and scheduler for the pipelined float16 log-scale multiplier.
// - After reset, streams the log2 and exp2 tables from an external table ROM into the multiplier LUTs.
// - Then shares the multiplier between NUM_REQ requesters with round-robin arbitration, one issue per cycle.
// - Tags each issued op and routes the result back to the requester that issued it.
// PARAMETERS
// NUM_REQ    4    number of requesters (>=1)
// FLOAT_LEN  16   float16 operand/result width
// MANT_LEN   10   log2 LUT entry width
// LUT_SIZE   128  entries per LUT; ROM address width = $clog2(LUT_SIZE)
// MUL_LAT    4    multiplier latency, mul_a/mul_b to mul_result (input reg + 2 stages + output reg)
// PORTS
// clk                input   1                    clock, all logic on rising edge
// rst                input   1                    synchronous, active-high reset
// req_valid          input   NUM_REQ              per-requester op valid
// req_a              input   NUM_REQ*FLOAT_LEN    operand a; requester i at [i*16 +: 16]
// req_b              input   NUM_REQ*FLOAT_LEN    operand b, same packing as req_a
// req_ready          output  NUM_REQ              one-hot grant; op accepted when valid & ready
// resp_valid         output  NUM_REQ              one-hot result strobe (no backpressure)
// resp_result        output  FLOAT_LEN            result for the requester flagged by resp_valid
// init_done          output  1                    LUT load complete; arbitration enabled
// idle               output  1                    init_done and no op in flight
// rom_rd_en          output  1                    table ROM read strobe
// rom_addr           output  $clog2(LUT_SIZE)     table ROM address
// rom_log2_data      input   MANT_LEN             ROM log2 entry; valid 1 cycle after rom_rd_en
// rom_exp2_data      input   FLOAT_LEN            ROM exp2 entry; valid 1 cycle after rom_rd_en
// mul_rst_n          output  1                    multiplier reset = ~rst (combinational)
// mul_lut_wr_en      output  1                    multiplier LUT write enable
// mul_log2_lut_data  output  MANT_LEN             = rom_log2_data (passthrough)
// mul_exp2_lut_data  output  FLOAT_LEN            = rom_exp2_data (passthrough)
// mul_a, mul_b       output  FLOAT_LEN            registered operands to the multiplier
// mul_result         input   FLOAT_LEN            multiplier result
// BEHAVIOUR
// - Reset: every registered output is 0 (req_ready, resp_valid, init_done, idle, rom_rd_en, rom_addr, mul_lut_wr_en, mul_a, mul_b). Tag pipe is cleared, RR pointer = NUM_REQ-1, FSM = LOAD.
// - FSM LOAD: rom_rd_en=1; rom_addr counts 0..LUT_SIZE-1, one per cycle. At LUT_SIZE-1 -> TAIL.
// - FSM TAIL: rom_rd_en=0; the last write completes -> RUN.
// - FSM RUN: init_done=1. RUN is terminal until rst.
// - mul_lut_wr_en = rom_rd_en delayed 1 cycle. It is high for exactly LUT_SIZE cycles, which the multiplier write pointer requires.
// - Timing of the load: rom_rd_en is high in cycles 0..LUT_SIZE-1 after reset release; init_done rises in cycle LUT_SIZE+1.
// - req_ready is all-zero outside RUN. Requests held during LOAD/TAIL are neither dropped nor granted.
// - Arbitration: combinational round-robin over req_valid. Search starts at rr_ptr+1 mod NUM_REQ; at most one grant per cycle.
// - rr_ptr updates to the granted index only on a grant. A continuous single requester is granted every cycle.
// - On grant in cycle t, the grant is registered: mul_a/mul_b <= req_a/req_b[gnt] at t+1.
// - Cycles without a grant drive mul_a = mul_b = 0.
// - Tag pipe is a shift register of {valid, id[$clog2(NUM_REQ)]} with depth MUL_LAT+1, entered at grant.
// - resp_valid[id] = tail valid, at cycle t+MUL_LAT+1 (5 cycles by default). resp_result = mul_result passthrough.
// - Responses return in grant order. Special values (NaN/Inf/zero) need no special handling; they are routed like any op.
// - idle = init_done & no valid tag in the pipe.
// - rst mid-operation: in-flight tags are discarded (no resp_valid after rst); mul_rst_n is asserted, clearing the LUT write pointer. The full LUT load reruns from addr 0.
// - Width rules: rr_ptr and tag id are $clog2(NUM_REQ) bits (min 1). The ROM address counter is one bit wider for terminal detection.
// - NUM_REQ=1: arbiter degenerates to req_ready = req_valid & init_done.
// STRUCTURE
// - Package lsm_pkg: FLOAT_LEN, EXP_LEN, MANT_LEN, LUT_SIZE and MUL_LAT constants; typedef enum {LOAD, TAIL, RUN} lsm_state_e; typedef struct packed {valid, id} lsm_tag_t.
// - One sub-module: lsm_rr_arbiter (NUM_REQ; req, advance -> one-hot gnt, gnt_idx), holding rr_ptr internally.
// - Top level holds the FSM, ROM counter, operand registers and tag pipe.
// TESTING
// 1. Release rst -> rom_addr 0..127 in cycles 0..127; mul_lut_wr_en high in cycles 1..128 (128 pulses); init_done=1 at cycle 129.
// 2. After init, req 0 sends a=16'h4000, b=16'h4000 -> req_ready[0] in the same cycle; resp_valid=4'b0001 exactly 5 cycles later with resp_result=16'h4400.
// 3. All 4 req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses in the same order, back-to-back.
// 4. req_valid[2]=1 from cycle 0 after reset -> req_ready stays 0 until cycle 129, then a single grant; idle returns to 1 six cycles later.
// 5. Assert rst for 1 cycle with 3 ops in flight -> no resp_valid afterwards; 128 mul_lut_wr_en pulses rerun; init_done returns 129 cycles after release.
// 6. Req 3 sends a=16'h7C00, b=16'h0000 -> resp_valid[3] with resp_result[14:0]=15'h7E00 (NaN).

Source files
------------

// File: rtl/log_scale_mul_sched_pkg.sv
// Shared constants and types for the log-scale multiplier scheduler.
package lsm_pkg;

    localparam int FLOAT_LEN     = 16;
    localparam int EXP_LEN       = 5;
    localparam int MANT_LEN      = 10;
    localparam int LUT_SIZE      = 128;
    localparam int MUL_LAT       = 4;
    localparam int LSM_NUM_REQ   = 4;
    localparam int ADDR_W        = $clog2(LUT_SIZE);
    localparam int TAG_ID_W      = (LSM_NUM_REQ > 1) ? $clog2(LSM_NUM_REQ) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        TAIL = 2'd1,
        RUN  = 2'd2
    } lsm_state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } lsm_tag_t;

endpackage

// File: rtl/log_scale_mul_sched_if.sv
// Requester-side handshake bundle: operand requests in, tagged results out.
interface log_scale_mul_sched_if #(
    parameter int NUM_REQ = lsm_pkg::LSM_NUM_REQ
);
    import lsm_pkg::*;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*FLOAT_LEN-1:0] req_a;
    logic [NUM_REQ*FLOAT_LEN-1:0] req_b;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           resp_valid;
    logic [FLOAT_LEN-1:0]         resp_result;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_result
    );

endinterface

// File: rtl/log_scale_mul_sched_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts just past the last winner.
module lsm_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    if (NUM_REQ == 1) begin : g_single
        assign gnt     = req & {NUM_REQ{advance}};
        assign gnt_idx = '0;
    end else begin : g_rr
        logic [ID_W-1:0] rr_ptr;
        logic [ID_W-1:0] cand;
        logic            found;

        // Rotating priority search over the requesters, gated by advance.
        always_comb begin
            gnt     = '0;
            gnt_idx = '0;
            found   = 1'b0;
            cand    = '0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!found && advance && req[cand]) begin
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                    found     = 1'b1;
                end
            end
        end

        // Pointer only moves on an actual grant so an idle cycle keeps fairness.
        always_ff @(posedge clk) begin
            if (rst) begin
                rr_ptr <= ID_W'(NUM_REQ - 1);
            end else if (found) begin
                rr_ptr <= gnt_idx;
            end
        end
    end

endmodule

// File: rtl/log_scale_mul_sched.sv
// Log-scale multiplier controller: loads the LUTs from ROM after reset, then
// shares the multiplier between requesters and routes tagged results back.
//
//   state | meaning
//   LOAD  | streaming ROM addresses 0..LUT_SIZE-1, one read per cycle
//   TAIL  | reads finished, waiting for the final LUT write to land
//   RUN   | tables loaded, arbitration enabled (terminal until rst)
module log_scale_mul_sched
    import lsm_pkg::*;
#(
    parameter int NUM_REQ = LSM_NUM_REQ
) (
    input  logic                 clk,
    input  logic                 rst,
    log_scale_mul_sched_if.slave bus,
    output logic                 init_done,
    output logic                 idle,
    output logic                 rom_rd_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [MANT_LEN-1:0]  rom_log2_data,
    input  logic [FLOAT_LEN-1:0] rom_exp2_data,
    output logic                 mul_rst_n,
    output logic                 mul_lut_wr_en,
    output logic [MANT_LEN-1:0]  mul_log2_lut_data,
    output logic [FLOAT_LEN-1:0] mul_exp2_lut_data,
    output logic [FLOAT_LEN-1:0] mul_a,
    output logic [FLOAT_LEN-1:0] mul_b,
    input  logic [FLOAT_LEN-1:0] mul_result
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    lsm_state_e          state_q;
    lsm_state_e          state_d;
    logic [ADDR_W:0]     addr_cnt;
    logic                rd_en_d;
    logic                init_done_d;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    lsm_tag_t            tag_in;
    lsm_tag_t            tag_pipe [MUL_LAT+1];
    logic                pipe_busy;

    assign mul_rst_n         = ~rst;
    assign mul_log2_lut_data = rom_log2_data;
    assign mul_exp2_lut_data = rom_exp2_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave TAIL only once the last read strobe has dropped, so
    // its write-enable cycle is the final one before RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: if (addr_cnt == (ADDR_W+1)'(LUT_SIZE - 1)) state_d = TAIL;
            TAIL: if (!rom_rd_en) state_d = RUN;
            RUN:  state_d = RUN;
            default: state_d = LOAD;
        endcase
    end

    // Output decode feeding the registered control outputs.
    always_comb begin
        rd_en_d     = (state_q == LOAD);
        init_done_d = (state_d == RUN);
    end

    // ROM read sequencing and LUT write enable (one cycle behind the read).
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_rd_en     <= 1'b0;
            rom_addr      <= '0;
            addr_cnt      <= '0;
            mul_lut_wr_en <= 1'b0;
            init_done     <= 1'b0;
        end else begin
            rom_rd_en     <= rd_en_d;
            mul_lut_wr_en <= rom_rd_en;
            init_done     <= init_done_d;
            if (rd_en_d) begin
                rom_addr <= addr_cnt[ADDR_W-1:0];
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    lsm_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (init_done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = gnt;

    // Register the winner's operands; idle cycles present zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (|gnt) begin
            mul_a <= bus.req_a[int'(gnt_idx)*FLOAT_LEN +: FLOAT_LEN];
            mul_b <= bus.req_b[int'(gnt_idx)*FLOAT_LEN +: FLOAT_LEN];
        end else begin
            mul_a <= '0;
            mul_b <= '0;
        end
    end

    assign tag_in = '{valid: (|gnt), id: TAG_ID_W'(gnt_idx)};

    // Tag pipe tracks the multiplier latency plus the operand register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Any in-flight tag means the multiplier is busy.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i <= MUL_LAT; i++) begin
            pipe_busy = pipe_busy | tag_pipe[i].valid;
        end
    end

    assign bus.resp_valid  = tag_pipe[MUL_LAT].valid ?
                             (NUM_REQ'(1) << tag_pipe[MUL_LAT].id) : '0;
    assign bus.resp_result = mul_result;
    assign idle            = init_done & ~pipe_busy;

endmodule

// File: tb/tb_log_scale_mul_sched.sv
// Self-checking bench for log_scale_mul_sched with ROM and multiplier models.
module tb_log_scale_mul_sched;
    import lsm_pkg::*;

    localparam int NR = LSM_NUM_REQ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    log_scale_mul_sched_if #(.NUM_REQ(NR)) bus ();

    logic                 init_done, idle, rom_rd_en, mul_rst_n, mul_lut_wr_en;
    logic [ADDR_W-1:0]    rom_addr;
    logic [MANT_LEN-1:0]  rom_log2_data, mul_log2_lut_data;
    logic [FLOAT_LEN-1:0] rom_exp2_data, mul_exp2_lut_data, mul_a, mul_b, mul_result;

    log_scale_mul_sched #(.NUM_REQ(NR)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .init_done         (init_done),
        .idle              (idle),
        .rom_rd_en         (rom_rd_en),
        .rom_addr          (rom_addr),
        .rom_log2_data     (rom_log2_data),
        .rom_exp2_data     (rom_exp2_data),
        .mul_rst_n         (mul_rst_n),
        .mul_lut_wr_en     (mul_lut_wr_en),
        .mul_log2_lut_data (mul_log2_lut_data),
        .mul_exp2_lut_data (mul_exp2_lut_data),
        .mul_a             (mul_a),
        .mul_b             (mul_b),
        .mul_result        (mul_result)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int rr_model = NR - 1;
    int wr_idx = 0;
    bit mon_en = 1'b0;

    typedef struct { int id; logic [15:0] res; int due; } exp_t;
    exp_t exp_q[$];

    logic [15:0] op_a [NR];
    logic [15:0] op_b [NR];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] rom_l2(input int i);
        return 10'((i * 37 + 5) % 1024);
    endfunction

    function automatic logic [15:0] rom_e2(input int i);
        return 16'(16'h3C00 + i * 3);
    endfunction

    // Reference float16 product (subnormals flushed, mantissa truncated).
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int ea, eb, e;
        logic [21:0] p;
        logic [9:0] m;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return 16'h7E00;
        if (ea == 31 || eb == 31) begin
            if (ea == 0 || eb == 0) return 16'h7E00;
            return {s, 5'h1F, 10'h000};
        end
        if (ea == 0 || eb == 0) return {s, 15'h0000};
        p = {11'h000, 1'b1, a[9:0]} * {11'h000, 1'b1, b[9:0]};
        e = ea + eb - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e <= 0) return {s, 15'h0000};
        return {s, 5'(e), m};
    endfunction

    // Table ROM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (rom_rd_en) begin
            rom_log2_data <= rom_l2(int'(rom_addr));
            rom_exp2_data <= rom_e2(int'(rom_addr));
        end
    end

    // Multiplier model: four registers from mul_a/mul_b to mul_result.
    logic [15:0] mpipe [4];
    always @(posedge clk) begin
        mpipe[0] <= fp16_mul(mul_a, mul_b);
        for (int i = 1; i < 4; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[3];

    // LUT write monitor: the k-th write after reset must carry ROM entry k.
    always @(negedge clk) begin
        if (!mul_rst_n) begin
            wr_idx = 0;
        end else if (mul_lut_wr_en) begin
            checks++;
            if (mul_log2_lut_data !== rom_l2(wr_idx) || mul_exp2_lut_data !== rom_e2(wr_idx))
                $display("FAIL lut_write idx=%0d got=%h/%h exp=%h/%h", wr_idx,
                         mul_log2_lut_data, mul_exp2_lut_data, rom_l2(wr_idx), rom_e2(wr_idx));
            else
                passed++;
            wr_idx = wr_idx + 1;
        end
    end

    // Response scoreboard: each grant expects one strobe exactly five cycles later.
    logic [NR-1:0] ev;
    logic [15:0]   er;
    always @(negedge clk) begin
        if (mon_en) begin
            ev = '0;
            er = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                ev[exp_q[0].id] = 1'b1;
                er = exp_q[0].res;
                void'(exp_q.pop_front());
            end
            checks++;
            if (bus.resp_valid !== ev || (ev != '0 && bus.resp_result !== er))
                $display("FAIL response cyc=%0d got=%b/%h exp=%b/%h", cyc,
                         bus.resp_valid, bus.resp_result, ev, er);
            else
                passed++;
        end
    end

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*16 +: 16] = op_a[i];
            bus.req_b[i*16 +: 16] = op_b[i];
        end
    endtask

    // Round-robin reference: first valid requester after the last winner.
    task automatic model_grant(input logic [NR-1:0] v, output logic [NR-1:0] er_o);
        int g;
        g = -1;
        er_o = '0;
        for (int k = 1; k <= NR; k++) begin
            if (g < 0 && v[(rr_model + k) % NR]) g = (rr_model + k) % NR;
        end
        if (g >= 0) begin
            er_o[g] = 1'b1;
            exp_q.push_back('{g, fp16_mul(op_a[g], op_b[g]), cyc + 5});
            rr_model = g;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; end
        drive_ops();
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        checks++;
        if ({rom_rd_en, rom_addr, mul_lut_wr_en, init_done, idle, mul_rst_n} !== '0)
            $display("FAIL reset_ctrl got=%b exp=0",
                     {rom_rd_en, rom_addr, mul_lut_wr_en, init_done, idle, mul_rst_n});
        else passed++;
        checks++;
        if ({mul_a, mul_b, bus.req_ready, bus.resp_valid} !== '0)
            $display("FAIL reset_data got=%h exp=0", {mul_a, mul_b, bus.req_ready, bus.resp_valid});
        else passed++;
    endtask

    // Releases rst (held from the previous cycle) and checks the load timeline.
    task automatic test_lut_load(input bit hold_req2);
        logic [NR-1:0] er_o;
        rr_model = NR - 1;
        exp_q.delete();
        op_a[2] = 16'($urandom);
        op_b[2] = 16'($urandom);
        drive_ops();
        bus.req_valid = hold_req2 ? NR'(4) : '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k <= 136; k++) begin
            @(posedge clk); #1;
            if (k == 130) bus.req_valid = '0;
            @(negedge clk);
            if (k <= 127) begin
                checks++;
                if (rom_rd_en !== 1'b1 || rom_addr !== ADDR_W'(k))
                    $display("FAIL load_read k=%0d got=%b/%0d exp=1/%0d", k, rom_rd_en, rom_addr, k);
                else passed++;
            end else begin
                checks++;
                if (rom_rd_en !== 1'b0)
                    $display("FAIL load_read_off k=%0d got=%b exp=0", k, rom_rd_en);
                else passed++;
            end
            checks++;
            if (mul_lut_wr_en !== (k >= 1 && k <= 128))
                $display("FAIL lut_wr_en k=%0d got=%b exp=%b", k, mul_lut_wr_en, (k >= 1 && k <= 128));
            else passed++;
            checks++;
            if (init_done !== (k >= 129))
                $display("FAIL init_done k=%0d got=%b exp=%b", k, init_done, (k >= 129));
            else passed++;
            if (k >= 129) model_grant(bus.req_valid, er_o);
            else er_o = '0;
            checks++;
            if (bus.req_ready !== er_o)
                $display("FAIL load_grant k=%0d got=%b exp=%b", k, bus.req_ready, er_o);
            else passed++;
            checks++;
            if (idle !== (k >= 129 && !(hold_req2 && k >= 130 && k <= 134)))
                $display("FAIL idle k=%0d got=%b exp=%b", k, idle,
                         (k >= 129 && !(hold_req2 && k >= 130 && k <= 134)));
            else passed++;
        end
        checks++;
        if (wr_idx != LUT_SIZE)
            $display("FAIL lut_pulses got=%0d exp=%0d", wr_idx, LUT_SIZE);
        else passed++;
    endtask

    task automatic test_single();
        logic [NR-1:0] er_o;
        @(posedge clk); #1;
        op_a[0] = 16'h4000;
        op_b[0] = 16'h4000;
        drive_ops();
        bus.req_valid = NR'(1);
        @(negedge clk);
        model_grant(bus.req_valid, er_o);
        checks++;
        if (bus.req_ready !== er_o || er_o !== NR'(1))
            $display("FAIL single_grant got=%b exp=%b", bus.req_ready, er_o);
        else passed++;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            bus.req_valid = '0;
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (mul_a !== 16'h4000 || mul_b !== 16'h4000)
                    $display("FAIL single_operands got=%h/%h exp=4000/4000", mul_a, mul_b);
                else passed++;
            end
            if (k == 2) begin
                checks++;
                if (mul_a !== 16'h0000 || mul_b !== 16'h0000)
                    $display("FAIL idle_operands got=%h/%h exp=0/0", mul_a, mul_b);
                else passed++;
            end
            if (k == 5) begin
                checks++;
                if (bus.resp_valid !== NR'(1) || bus.resp_result !== 16'h4400)
                    $display("FAIL single_resp got=%b/%h exp=0001/4400", bus.resp_valid, bus.resp_result);
                else passed++;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) $display("FAIL single_idle got=%b exp=1", idle);
        else passed++;
    endtask

    task automatic test_nan();
        logic [NR-1:0] er_o;
        @(posedge clk); #1;
        op_a[3] = 16'h7C00;
        op_b[3] = 16'h0000;
        drive_ops();
        bus.req_valid = NR'(8);
        @(negedge clk);
        model_grant(bus.req_valid, er_o);
        checks++;
        if (bus.req_ready !== er_o) $display("FAIL nan_grant got=%b exp=%b", bus.req_ready, er_o);
        else passed++;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus.req_valid = '0;
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (bus.resp_valid !== NR'(8) || bus.resp_result[14:0] !== 15'h7E00)
                    $display("FAIL nan_resp got=%b/%h exp=1000/7e00", bus.resp_valid, bus.resp_result[14:0]);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] er_o;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin op_a[i] = 16'($urandom); op_b[i] = 16'($urandom); end
            drive_ops();
            bus.req_valid = '1;
            @(negedge clk);
            model_grant(bus.req_valid, er_o);
            checks++;
            if (bus.req_ready !== er_o || er_o !== (NR'(1) << (k % NR)))
                $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, bus.req_ready, er_o);
            else passed++;
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (7) @(posedge clk);
    endtask

    task automatic test_random();
        logic [NR-1:0] er_o;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin op_a[i] = 16'($urandom); op_b[i] = 16'($urandom); end
            drive_ops();
            bus.req_valid = NR'($urandom);
            @(negedge clk);
            model_grant(bus.req_valid, er_o);
            checks++;
            if (bus.req_ready !== er_o)
                $display("FAIL rand_grant k=%0d got=%b exp=%b", k, bus.req_ready, er_o);
            else passed++;
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++;
        if (idle !== 1'b1 || exp_q.size() != 0)
            $display("FAIL rand_drain got=%b/%0d exp=1/0", idle, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset_midflight();
        logic [NR-1:0] er_o;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin op_a[i] = 16'($urandom); op_b[i] = 16'($urandom); end
            drive_ops();
            bus.req_valid = '1;
            @(negedge clk);
            model_grant(bus.req_valid, er_o);
            checks++;
            if (bus.req_ready !== er_o)
                $display("FAIL mid_grant k=%0d got=%b exp=%b", k, bus.req_ready, er_o);
            else passed++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_valid = '0;
        exp_q.delete();
        test_lut_load(1'b0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        test_reset();
        test_lut_load(1'b1);
        test_single();
        test_nan();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
